// File: rtl/gemm_inst_sequencer.sv
// Instruction sequencer between instruction fetch and systolic_array_top: decodes
// LD/ST/GEMM/DRAINSYS/SETEND, drives the SRAM ports and times the array phases.
module gemm_inst_sequencer #(
    parameter int NUM_ROW              = 4,
    parameter int NUM_COL              = 4,
    parameter int DATA_WIDTH           = 16,
    parameter int OUT_DATA_WIDTH       = 16,
    parameter int LOG2_SRAM_BANK_DEPTH = 5,
    parameter int CTRL_WIDTH           = 4,
    parameter int INST_WIDTH           = 16,
    parameter int WARMUP_CYCLES        = NUM_ROW + NUM_COL - 1,
    parameter int DRAIN_CYCLES         = NUM_ROW + NUM_COL,
    parameter int LD_WIDTH             = ((NUM_ROW > NUM_COL) ? NUM_ROW : NUM_COL) * DATA_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_inst_valid,
    input  logic [INST_WIDTH-1:0]               i_inst,
    output logic                                o_inst_ready,
    input  logic                                i_ld_valid,
    input  logic [LD_WIDTH-1:0]                 i_ld_data,
    output logic                                o_ld_ready,
    output logic                                o_top_wr_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_top_wr_addr,
    output logic [NUM_COL*DATA_WIDTH-1:0]       o_top_wr_data,
    output logic                                o_left_wr_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_left_wr_addr,
    output logic [NUM_ROW*DATA_WIDTH-1:0]       o_left_wr_data,
    output logic                                o_down_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_down_rd_addr,
    input  logic [NUM_COL*OUT_DATA_WIDTH-1:0]   i_down_rd_data,
    output logic                                o_st_valid,
    output logic [NUM_COL*OUT_DATA_WIDTH-1:0]   o_st_data,
    input  logic                                i_st_ready,
    output logic [CTRL_WIDTH-1:0]               o_ctrl_state,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_top_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_left_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_down_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_top_sram_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_left_sram_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_down_sram_rd_end_addr,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_illegal
);

    localparam int AW      = LOG2_SRAM_BANK_DEPTH;
    localparam int TW      = NUM_COL * DATA_WIDTH;
    localparam int LW      = NUM_ROW * DATA_WIDTH;
    localparam int SW      = NUM_COL * OUT_DATA_WIDTH;
    localparam int DEPTH   = 1 << AW;
    localparam int MAX_WD  = (WARMUP_CYCLES > DRAIN_CYCLES) ? WARMUP_CYCLES : DRAIN_CYCLES;
    localparam int CNT_MAX = (MAX_WD > DEPTH) ? MAX_WD : DEPTH;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [3:0] {
        OP_SETEND   = 4'h1,
        OP_LD       = 4'h2,
        OP_ST       = 4'h3,
        OP_GEMM     = 4'h4,
        OP_DRAINSYS = 4'h5
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE, S_LD, S_ST_RD, S_ST_CAP, S_ST_WAIT, S_WARMUP, S_STEADY, S_DRAIN
    } state_e;

    logic [3:0]    opcode;
    logic [1:0]    buf_id;
    logic [AW-1:0] inst_addr;
    logic          inst_fire;
    logic          unused_mem_loc;

    assign opcode         = i_inst[INST_WIDTH-1 -: 4];
    assign buf_id         = i_inst[INST_WIDTH-5 -: 2];
    assign inst_addr      = i_inst[AW-1:0];
    assign unused_mem_loc = ^i_inst[INST_WIDTH-7:AW];

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CTRL_WIDTH-1:0]   ctrl_q, ctrl_d;
    logic                    done_q, done_d;
    logic                    illegal_q, illegal_d;
    logic                    top_wr_en_q, top_wr_en_d;
    logic [AW-1:0]           top_wr_addr_q, top_wr_addr_d;
    logic [TW-1:0]           top_wr_data_q, top_wr_data_d;
    logic                    left_wr_en_q, left_wr_en_d;
    logic [AW-1:0]           left_wr_addr_q, left_wr_addr_d;
    logic [LW-1:0]           left_wr_data_q, left_wr_data_d;
    logic                    down_rd_en_q, down_rd_en_d;
    logic [AW-1:0]           down_rd_addr_q, down_rd_addr_d;
    logic                    st_valid_q, st_valid_d;
    logic [SW-1:0]           st_data_q, st_data_d;
    logic [AW-1:0]           start_q, start_d;
    logic [AW-1:0]           top_end_q, top_end_d;
    logic [AW-1:0]           left_end_q, left_end_d;
    logic [AW-1:0]           down_end_q, down_end_d;
    logic [AW-1:0]           ld_addr_q, ld_addr_d;
    logic                    ld_left_q, ld_left_d;
    logic [AW-1:0]           steady_m1;

    assign inst_fire = i_inst_valid && o_inst_ready;
    // STEADY length minus one; wraps mod depth so end == start-1 yields a full bank.
    assign steady_m1 = top_end_q - start_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d        = state_q;
        cnt_d          = cnt_q;
        done_d         = 1'b0;
        illegal_d      = illegal_q;
        top_wr_en_d    = 1'b0;
        top_wr_addr_d  = top_wr_addr_q;
        top_wr_data_d  = top_wr_data_q;
        left_wr_en_d   = 1'b0;
        left_wr_addr_d = left_wr_addr_q;
        left_wr_data_d = left_wr_data_q;
        down_rd_en_d   = 1'b0;
        down_rd_addr_d = down_rd_addr_q;
        st_valid_d     = st_valid_q;
        st_data_d      = st_data_q;
        start_d        = start_q;
        top_end_d      = top_end_q;
        left_end_d     = left_end_q;
        down_end_d     = down_end_q;
        ld_addr_d      = ld_addr_q;
        ld_left_d      = ld_left_q;

        case (state_q)
            S_IDLE: begin
                if (inst_fire) begin
                    case (opcode)
                        OP_SETEND: begin
                            done_d = 1'b1;
                            case (buf_id)
                                2'd0:    top_end_d  = inst_addr;
                                2'd1:    left_end_d = inst_addr;
                                2'd2:    down_end_d = inst_addr;
                                default: ;
                            endcase
                        end
                        OP_LD: begin
                            if (buf_id[1]) begin
                                illegal_d = 1'b1;
                                done_d    = 1'b1;
                            end else begin
                                state_d   = S_LD;
                                ld_addr_d = inst_addr;
                                ld_left_d = buf_id[0];
                            end
                        end
                        OP_ST: begin
                            state_d        = S_ST_RD;
                            down_rd_en_d   = 1'b1;
                            down_rd_addr_d = inst_addr;
                        end
                        OP_GEMM: begin
                            state_d = S_WARMUP;
                            start_d = inst_addr;
                            cnt_d   = CNT_W'(WARMUP_CYCLES - 1);
                        end
                        OP_DRAINSYS: begin
                            state_d = S_DRAIN;
                            cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                        end
                        default: begin
                            illegal_d = 1'b1;
                            done_d    = 1'b1;
                        end
                    endcase
                end
            end
            S_LD: begin
                if (i_ld_valid) begin
                    if (ld_left_q) begin
                        left_wr_en_d   = 1'b1;
                        left_wr_addr_d = ld_addr_q;
                        left_wr_data_d = i_ld_data[LW-1:0];
                    end else begin
                        top_wr_en_d    = 1'b1;
                        top_wr_addr_d  = ld_addr_q;
                        top_wr_data_d  = i_ld_data[TW-1:0];
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ST_RD:  state_d = S_ST_CAP;
            S_ST_CAP: begin
                st_data_d  = i_down_rd_data;
                st_valid_d = 1'b1;
                state_d    = S_ST_WAIT;
            end
            S_ST_WAIT: begin
                if (i_st_ready) begin
                    st_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_WARMUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STEADY;
                    cnt_d   = CNT_W'(steady_m1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STEADY: begin
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_WARMUP: ctrl_d = CTRL_WIDTH'(1);
            S_STEADY: ctrl_d = CTRL_WIDTH'(2);
            S_DRAIN:  ctrl_d = CTRL_WIDTH'(3);
            default:  ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates only; every register, wide data included, is reset so an abort leaves nothing stale.
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            ctrl_q         <= '0;
            done_q         <= 1'b0;
            illegal_q      <= 1'b0;
            top_wr_en_q    <= 1'b0;
            top_wr_addr_q  <= '0;
            top_wr_data_q  <= '0;
            left_wr_en_q   <= 1'b0;
            left_wr_addr_q <= '0;
            left_wr_data_q <= '0;
            down_rd_en_q   <= 1'b0;
            down_rd_addr_q <= '0;
            st_valid_q     <= 1'b0;
            st_data_q      <= '0;
            start_q        <= '0;
            top_end_q      <= '0;
            left_end_q     <= '0;
            down_end_q     <= '0;
            ld_addr_q      <= '0;
            ld_left_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ctrl_q         <= ctrl_d;
            done_q         <= done_d;
            illegal_q      <= illegal_d;
            top_wr_en_q    <= top_wr_en_d;
            top_wr_addr_q  <= top_wr_addr_d;
            top_wr_data_q  <= top_wr_data_d;
            left_wr_en_q   <= left_wr_en_d;
            left_wr_addr_q <= left_wr_addr_d;
            left_wr_data_q <= left_wr_data_d;
            down_rd_en_q   <= down_rd_en_d;
            down_rd_addr_q <= down_rd_addr_d;
            st_valid_q     <= st_valid_d;
            st_data_q      <= st_data_d;
            start_q        <= start_d;
            top_end_q      <= top_end_d;
            left_end_q     <= left_end_d;
            down_end_q     <= down_end_d;
            ld_addr_q      <= ld_addr_d;
            ld_left_q      <= ld_left_d;
        end
    end

    // Store retire is signalled in the transfer cycle itself, so it bypasses done_q.
    assign o_done       = done_q || (state_q == S_ST_WAIT && i_st_ready && !rst);
    assign o_inst_ready = (state_q == S_IDLE) && !rst;
    assign o_ld_ready   = (state_q == S_LD);
    assign o_busy       = (state_q != S_IDLE);
    assign o_illegal    = illegal_q;
    assign o_ctrl_state = ctrl_q;

    assign o_top_wr_en    = top_wr_en_q;
    assign o_top_wr_addr  = top_wr_addr_q;
    assign o_top_wr_data  = top_wr_data_q;
    assign o_left_wr_en   = left_wr_en_q;
    assign o_left_wr_addr = left_wr_addr_q;
    assign o_left_wr_data = left_wr_data_q;
    assign o_down_rd_en   = down_rd_en_q;
    assign o_down_rd_addr = down_rd_addr_q;
    assign o_st_valid     = st_valid_q;
    assign o_st_data      = st_data_q;

    assign o_top_sram_rd_start_addr  = start_q;
    assign o_left_sram_rd_start_addr = start_q;
    assign o_down_sram_rd_start_addr = start_q;
    assign o_top_sram_rd_end_addr    = top_end_q;
    assign o_left_sram_rd_end_addr   = left_end_q;
    assign o_down_sram_rd_end_addr   = down_end_q;

endmodule

// File: doc/gemm_inst_sequencer.md
Name: gemm_inst_sequencer

Overview:
Parametrised instruction sequencer that replaces hand-registered control glue between instruction fetch and systolic_array_top. It accepts 16-bit LD/ST/GEMM/DRAINSYS/SETEND instructions over a valid/ready port and drives top/left SRAM writes, down-SRAM reads and ctrl_state. It times the IDLE→WARMUP→STEADY→DRAIN phases itself.
All array-facing outputs are registered. It sits between the instruction fetch unit and systolic_array_top.

Parameters:
NUM_ROW, 4, systolic rows (left bank width in words)
NUM_COL, 4, systolic columns (top/down bank width in words)
DATA_WIDTH, 16, input word width
OUT_DATA_WIDTH, 16, down-SRAM word width
LOG2_SRAM_BANK_DEPTH, 5, SRAM address width; depth D = 2^LOG2_SRAM_BANK_DEPTH
CTRL_WIDTH, 4, ctrl_state width
INST_WIDTH, 16, instruction width: opcode[15:12], buf_id[11:10], mem_loc[9:0]
WARMUP_CYCLES, NUM_ROW+NUM_COL-1, cycles held in WARMUP
DRAIN_CYCLES, NUM_ROW+NUM_COL, cycles held in DRAIN
LD_WIDTH, max(NUM_ROW,NUM_COL)*DATA_WIDTH, load data bus width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
i_inst_valid  in  1  instruction valid
i_inst  in  INST_WIDTH  instruction
o_inst_ready  out  1  sequencer can accept an instruction
i_ld_valid  in  1  load data beat valid
i_ld_data  in  LD_WIDTH  load data
o_ld_ready  out  1  load beat accepted
o_top_wr_en / o_top_wr_addr / o_top_wr_data  out  1 / LOG2_SRAM_BANK_DEPTH / NUM_COL*DATA_WIDTH  top SRAM write
o_left_wr_en / o_left_wr_addr / o_left_wr_data  out  1 / LOG2_SRAM_BANK_DEPTH / NUM_ROW*DATA_WIDTH  left SRAM write
o_down_rd_en / o_down_rd_addr  out  1 / LOG2_SRAM_BANK_DEPTH  down SRAM read
i_down_rd_data  in  NUM_COL*OUT_DATA_WIDTH  down SRAM read data, 1-cycle latency
o_st_valid / o_st_data  out  1 / NUM_COL*OUT_DATA_WIDTH  store result
i_st_ready  in  1  store consumer ready
o_ctrl_state  out  CTRL_WIDTH  IDLE=0, WARMUP=1, STEADY=2, DRAIN=3
o_{top,left,down}_sram_rd_start_addr  out  LOG2_SRAM_BANK_DEPTH each  GEMM start addresses
o_{top,left,down}_sram_rd_end_addr  out  LOG2_SRAM_BANK_DEPTH each  GEMM end addresses
o_busy  out  1  FSM not in S_IDLE
o_done  out  1  one-cycle pulse on instruction retire
o_illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Reset: all outputs 0, all end registers 0, FSM in S_IDLE; o_inst_ready returns to 1 on the first cycle after reset deasserts. A reset in any state aborts the operation with no further writes or reads.
- o_inst_ready=1 only in S_IDLE. An instruction is accepted on i_inst_valid&o_inst_ready.
- addr = mem_loc[LOG2_SRAM_BANK_DEPTH-1:0]; upper mem_loc bits are ignored.
- SETEND (0001): buf_id 0/1/2 sets the top/left/down end register to addr; buf_id 3 is ignored. Retires in 1 cycle: o_done in the cycle after acceptance.
- LD (0010), buf_id 0 = top, 1 = left:
  - Enter S_LD; o_ld_ready=1 in S_LD.
  - On i_ld_valid: next cycle, wr_en=1 for exactly one cycle, addr as given, data = i_ld_data low slice; o_done with that wr_en.
  - buf_id 2/3: illegal.
- ST (0010+1=0011):
  - Cycle after acceptance: o_down_rd_en=1, o_down_rd_addr=addr.
  - One cycle later: capture i_down_rd_data and assert o_st_valid.
  - o_st_valid and o_st_data are held stable until i_st_ready; the transfer cycle pulses o_done and returns to S_IDLE.
- GEMM (0100):
  - All three start addresses := addr.
  - STEADY length L = (top_end - addr + 1) mod D; L=0 means D cycles.
  - From the cycle after acceptance, o_ctrl_state = WARMUP for WARMUP_CYCLES, then STEADY for L, then DRAIN for DRAIN_CYCLES, then IDLE.
  - o_done coincides with the first IDLE cycle.
  - Start/end outputs are held for the whole operation.
- DRAINSYS (0101): DRAIN for DRAIN_CYCLES, then IDLE plus o_done.
- Any other opcode, or LD with buf_id>1: set o_illegal (cleared only by rst), retire in 1 cycle with o_done, no side effects.
- Only one instruction is in flight at a time; ld/st handshakes are ignored outside S_LD and S_ST_WAIT.

Test Plan:
- Reset, then LD 0x2003 with i_ld_valid and data 0x0004_0003_0002_0001 → one-cycle o_top_wr_en, addr 3, that data, o_done in the same cycle; o_left_wr_en stays 0.
- LD 0x2405, with i_ld_valid held low 5 cycles then asserted → o_ld_ready held for 6 cycles; single o_left_wr_en at addr 5 after the valid beat.
- SETEND 0x1007, then GEMM 0x4004 → start addrs = 4, top end = 7; ctrl_state is 1 for 7 cycles, 2 for 4 cycles, 3 for 8 cycles, then 0 with o_done.
- Wrap: SETEND 0x1001, then GEMM 0x401E → STEADY lasts 4 cycles (addresses 30, 31, 0, 1).
- ST 0x3002, with down data 0xBEEF at addr 2 and i_st_ready low 3 cycles → rd_en at cycle+1; o_st_valid held with 0xBEEF until ready; o_done on the transfer cycle.
- Opcode 0xF000, then rst asserted mid-GEMM → o_illegal=1 sticky until rst; rst returns ctrl_state to 0 and clears o_illegal on the next edge.
